// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between NUM_INPUTS requesters.
// Multi-beat packets hold the grant until their last beat; output is a single register stage.
module stream_arbiter #(
  parameter  int  NUM_INPUTS = 2,
  parameter  int  DATA_WIDTH = 1,
  parameter  type TYPE       = logic [DATA_WIDTH-1:0],
  localparam int  SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] in_valid,
  output logic [NUM_INPUTS-1:0] in_ready,
  input  TYPE                   in_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0] in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output TYPE                   out_data,
  output logic                  out_last,
  output logic [SEL_WIDTH-1:0]  out_sel
);

  if (NUM_INPUTS < 2) begin : g_bad_num_inputs
    $fatal(1, "stream_arbiter: NUM_INPUTS must be at least 2");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_r;
  logic [SEL_WIDTH-1:0] prio_r;
  logic [SEL_WIDTH-1:0] lock_idx_r;

  logic                 can_load_s;
  logic                 found_s;
  logic [SEL_WIDTH-1:0] cand_s;
  logic [SEL_WIDTH-1:0] probe_s;
  logic                 accept_s;

  // Explicit wrap so non-power-of-2 requester counts rotate correctly.
  function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] idx);
    if (idx == SEL_WIDTH'(NUM_INPUTS - 1)) begin
      return '0;
    end else begin
      return idx + SEL_WIDTH'(1);
    end
  endfunction

  assign can_load_s = !out_valid || out_ready;

  // Candidate selection: locked owner, or first valid requester after the last winner.
  always_comb begin
    found_s = 1'b0;
    cand_s  = '0;
    probe_s = wrap_inc(prio_r);
    case (state_r)
      LOCKED: begin
        found_s = 1'b1;
        cand_s  = lock_idx_r;
      end
      IDLE: begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (!found_s && in_valid[probe_s]) begin
            found_s = 1'b1;
            cand_s  = probe_s;
          end else begin
            found_s = found_s;
          end
          probe_s = wrap_inc(probe_s);
        end
      end
      default: begin
        found_s = 1'b0;
        cand_s  = '0;
      end
    endcase
  end

  // Ready goes to the candidate only, and only when the output register can take a beat.
  always_comb begin
    in_ready = '0;
    if (found_s && can_load_s && !rst) begin
      in_ready[cand_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  assign accept_s = found_s && in_valid[cand_s] && in_ready[cand_s];

  // Lock FSM, rotation pointer and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      prio_r     <= SEL_WIDTH'(NUM_INPUTS - 1);
      lock_idx_r <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_sel    <= '0;
    end else begin
      if (accept_s) begin
        out_valid <= 1'b1;
        out_data  <= in_data[cand_s];
        out_last  <= in_last[cand_s];
        out_sel   <= cand_s;
        prio_r    <= cand_s;
        if (in_last[cand_s]) begin
          state_r <= IDLE;
        end else begin
          state_r    <= LOCKED;
          lock_idx_r <= cand_s;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter with four 8-bit requesters.
// Expected values are hand-computed from the arbitration rules.
module tb_stream_arbiter;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] in_data [N];
  logic [3:0] in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_sel;

  int n_cmp;
  int n_err;

  stream_arbiter #(
    .NUM_INPUTS(N),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] sel, input logic [7:0] data,
                         input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sel"},   32'(out_sel),   32'(sel));
    chk({tag, ".data"},  32'(out_data),  32'(data));
    chk({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_last   = 4'h0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = 8'h00;

    // Reset state, with requests pending
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_sel",   32'(out_sel),   32'd0);
    chk("rst.out_last",  32'(out_last),  32'd0);
    in_valid = 4'h0;
    cyc();
    rst = 1'b0;
    cyc();

    // Single requester, two-beat packet
    in_valid   = 4'b0100;
    in_data[2] = 8'h0A;
    in_last    = 4'b0000;
    #1 chk("single.rdy0", 32'(in_ready), 32'b0100);
    cyc();
    chk_out("single.b0", 2'd2, 8'h0A, 1'b0);
    in_data[2] = 8'h0B;
    in_last    = 4'b0100;
    #1 chk("single.rdy1", 32'(in_ready), 32'b0100);
    cyc();
    chk_out("single.b1", 2'd2, 8'h0B, 1'b1);
    in_valid = 4'b0000;
    cyc();
    chk("single.drain", 32'(out_valid), 32'd0);

    // Round-robin rotation from reset priority
    do_reset();
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i] = 8'h10 + 8'(i);
    #1 chk("rr.rdy_first", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk_out("rr.beat", 2'(k % 4), 8'h10 + 8'(k % 4), 1'b1);
      chk("rr.rdy", 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
    end

    // Wrap-around: last winner 1, then 3, then 0 ahead of 3
    in_valid = 4'b1001;
    #1 chk("wrap.rdy3", 32'(in_ready), 32'b1000);
    cyc();
    chk_out("wrap.g3", 2'd3, 8'h13, 1'b1);
    chk("wrap.rdy0", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("wrap.g0", 2'd0, 8'h10, 1'b1);
    in_valid = 4'b0000;
    cyc();

    // Packet lock: input 1 three beats with a two-cycle gap, input 0 waiting
    in_valid   = 4'b0011;
    in_data[0] = 8'h20;
    in_data[1] = 8'h31;
    in_last    = 4'b0001;
    #1 chk("lock.rdy_b0", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("lock.b0", 2'd1, 8'h31, 1'b0);
    in_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1 chk("lock.gap_rdy", 32'(in_ready), 32'b0010);
      cyc();
      chk("lock.gap_valid", 32'(out_valid), 32'd0);
    end
    in_valid   = 4'b0011;
    in_data[1] = 8'h32;
    #1 chk("lock.rdy_b1", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("lock.b1", 2'd1, 8'h32, 1'b0);
    in_data[1] = 8'h33;
    in_last    = 4'b0011;
    #1 chk("lock.rdy_b2", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("lock.b2", 2'd1, 8'h33, 1'b1);
    in_valid = 4'b0001;
    #1 chk("lock.rdy_after", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("lock.in0", 2'd0, 8'h20, 1'b1);
    in_valid = 4'b0000;
    cyc();

    // Backpressure: five stalled cycles, then drain and accept together
    in_valid   = 4'b1100;
    in_data[2] = 8'h42;
    in_data[3] = 8'h43;
    in_last    = 4'b1100;
    cyc();
    chk_out("bp.first", 2'd2, 8'h42, 1'b1);
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    #1 chk("bp.rdy_stall", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_out("bp.hold", 2'd2, 8'h42, 1'b1);
      chk("bp.hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp.rdy_release", 32'(in_ready), 32'b1000);
    cyc();
    chk_out("bp.next", 2'd3, 8'h43, 1'b1);
    in_valid = 4'b0000;
    cyc();
    chk("bp.drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a four-beat packet from input 2
    in_valid   = 4'b0100;
    in_data[2] = 8'h51;
    in_last    = 4'b0000;
    cyc();
    chk_out("rstpkt.b0", 2'd2, 8'h51, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstpkt.valid", 32'(out_valid), 32'd0);
    chk("rstpkt.rdy",   32'(in_ready),  32'd0);
    cyc();
    rst        = 1'b0;
    in_valid   = 4'b0101;
    in_data[0] = 8'h60;
    in_data[2] = 8'h52;
    in_last    = 4'b0001;
    #1 chk("rstpkt.rdy_after", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("rstpkt.g0", 2'd0, 8'h60, 1'b1);
    in_valid = 4'b0000;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
